// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data memory controller.
// Holds the FSM state encoding, default base address and byte-swap helper.
package dmem_pkg;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0010_0000;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between a core data port and data_mem_ctrl.
// Signal names follow the core-side convention (_in driven by master, _o by slave).
interface data_mem_ctrl_if;

    logic        data_req_in;
    logic [31:0] data_add_in;
    logic        data_we_in;
    logic [3:0]  data_be_in;
    logic [31:0] data_wdata_in;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;

    modport master (
        output data_req_in, data_add_in, data_we_in, data_be_in, data_wdata_in,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
    );

    modport slave (
        input  data_req_in, data_add_in, data_we_in, data_be_in, data_wdata_in,
        output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
    );

endinterface

// File: rtl/dmem_array.sv
// Word-wide storage with per-byte write enables and a registered read port.
// Written so synthesis maps it onto byte-enabled block RAM.
module dmem_array #(
    parameter int unsigned DEPTH = 8192
) (
    input  logic                     clk,
    input  logic [3:0]               we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [31:0]              wdata_i,
    input  logic                     re_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [31:0]              rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we_i[i]) begin
                mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// Single-cycle-latency data memory with optional byte-swapped storage and
// a post-reset clearing pass that zero-fills one word per cycle.
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH          = 8192,
    parameter logic [31:0] BASE_ADDR      = DEFAULT_BASE_ADDR,
    parameter bit          SWAP_BYTES     = 1'b1,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    data_mem_ctrl_if.slave bus,
    output logic           busy_o
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [0:0]      S_INIT   = ST_INIT;
    localparam logic [0:0]      S_READY  = ST_READY;
    localparam logic [AW-1:0]   LAST_IDX = AW'(DEPTH - 1);

    logic [0:0]    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          rvalid_q, err_q, rd_q;

    logic          init_active, gnt, in_range, acc_write, acc_read;
    logic [AW-1:0] word_idx;
    logic [3:0]    lane_be;
    logic [31:0]   lane_wdata;
    logic [3:0]    arr_we;
    logic [AW-1:0] arr_waddr;
    logic [31:0]   arr_wdata;
    logic [31:0]   arr_rdata;
    logic [31:0]   rdata_native;
    logic          unused_addr_lsbs;

    // rst gates gnt so nothing is accepted while reset is held, even when
    // the reset state is READY.
    assign init_active = (state_q == S_INIT) && !rst;
    assign gnt         = bus.data_req_in && (state_q == S_READY) && !rst;

    // BASE_ADDR is aligned to the array size, so the upper bits alone decide range.
    assign in_range  = (bus.data_add_in[31:AW+2] == BASE_ADDR[31:AW+2]);
    assign word_idx  = bus.data_add_in[AW+1:2];
    assign acc_write = gnt && bus.data_we_in && in_range;
    assign acc_read  = gnt && !bus.data_we_in && in_range;
    assign unused_addr_lsbs = ^bus.data_add_in[1:0];

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam int SL = SWAP_BYTES ? 3 - gi : gi;
        assign lane_be[SL]             = bus.data_be_in[gi];
        assign lane_wdata[8*SL +: 8]   = bus.data_wdata_in[8*gi +: 8];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == S_INIT) begin
            cnt_d = cnt_q + AW'(1);
            if (cnt_q == LAST_IDX) begin
                state_d = S_READY;
            end
        end
    end

    always_comb begin
        arr_we    = '0;
        arr_waddr = word_idx;
        arr_wdata = lane_wdata;
        if (init_active) begin
            arr_we    = 4'hF;
            arr_waddr = cnt_q;
            arr_wdata = '0;
        end else if (acc_write) begin
            arr_we = lane_be;
        end
    end

    dmem_array #(
        .DEPTH(DEPTH)
    ) u_array (
        .clk    (clk),
        .we_i   (arr_we),
        .waddr_i(arr_waddr),
        .wdata_i(arr_wdata),
        .re_i   (acc_read),
        .raddr_i(word_idx),
        .rdata_o(arr_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= CLEAR_ON_RESET ? S_INIT : S_READY;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rd_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= gnt;
            err_q    <= gnt && !in_range;
            rd_q     <= acc_read;
        end
    end

    assign rdata_native = SWAP_BYTES ? bswap32(arr_rdata) : arr_rdata;

    assign bus.data_gnt_o    = gnt;
    assign bus.data_rvalid_o = rvalid_q;
    assign bus.data_err_o    = err_q;
    assign bus.data_rdata_o  = rd_q ? rdata_native : 32'h0;
    assign busy_o            = (state_q == S_INIT);

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: two DEPTH=16 instances (swapped and native lanes)
// driven identically and checked against an address-level memory model.
module tb_data_mem_ctrl;

    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0010_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy_sw, busy_ns;

    data_mem_ctrl_if bus_sw ();
    data_mem_ctrl_if bus_ns ();

    data_mem_ctrl #(
        .DEPTH(DEPTH), .BASE_ADDR(BASE), .SWAP_BYTES(1'b1), .CLEAR_ON_RESET(1'b1)
    ) dut_sw (
        .clk(clk), .rst(rst), .bus(bus_sw), .busy_o(busy_sw)
    );

    data_mem_ctrl #(
        .DEPTH(DEPTH), .BASE_ADDR(BASE), .SWAP_BYTES(1'b0), .CLEAR_ON_RESET(1'b1)
    ) dut_ns (
        .clk(clk), .rst(rst), .bus(bus_ns), .busy_o(busy_ns)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model [DEPTH];

    logic        c_gnt    [2];
    logic        c_rvalid [2];
    logic        c_err    [2];
    logic        c_busy   [2];
    logic [31:0] c_rdata  [2];

    task automatic drive(input logic req, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd);
        bus_sw.data_req_in = req;  bus_ns.data_req_in = req;
        bus_sw.data_we_in  = we;   bus_ns.data_we_in  = we;
        bus_sw.data_add_in = addr; bus_ns.data_add_in = addr;
        bus_sw.data_be_in  = be;   bus_ns.data_be_in  = be;
        bus_sw.data_wdata_in = wd; bus_ns.data_wdata_in = wd;
    endtask

    task automatic sample();
        c_gnt[0] = bus_sw.data_gnt_o;       c_gnt[1] = bus_ns.data_gnt_o;
        c_rvalid[0] = bus_sw.data_rvalid_o; c_rvalid[1] = bus_ns.data_rvalid_o;
        c_err[0] = bus_sw.data_err_o;       c_err[1] = bus_ns.data_err_o;
        c_rdata[0] = bus_sw.data_rdata_o;   c_rdata[1] = bus_ns.data_rdata_o;
        c_busy[0] = busy_sw;                c_busy[1] = busy_ns;
    endtask

    // One bus cycle: drive after the edge, sample at the falling edge.
    task automatic step(input logic req, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd);
        drive(req, we, addr, be, wd);
        @(negedge clk);
        sample();
        $display("txn t=%0t req=%b we=%b addr=%h be=%b wd=%h | gnt=%b rv=%b rd=%h err=%b",
                 $time, req, we, addr, be, wd, c_gnt[0], c_rvalid[0], c_rdata[0], c_err[0]);
        @(posedge clk);
        #1;
    endtask

    // Memory model at the address level: range check, byte lanes, native order.
    task automatic model_access(input logic we, input logic [31:0] addr, input logic [3:0] be,
                                input logic [31:0] wd, output logic e_err, output logic [31:0] e_rd);
        longint off;
        int     idx;
        off   = longint'(addr) - longint'(BASE);
        e_err = 1'b0;
        e_rd  = 32'h0;
        if (off < 0 || off >= longint'(DEPTH * 4)) begin
            e_err = 1'b1;
        end else begin
            idx = int'(off / 4);
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) model[idx][8*i +: 8] = wd[8*i +: 8];
                end
            end else begin
                e_rd = model[idx];
            end
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    endtask

    task automatic count_busy(output int n0, output int n1, output bit gnt_early);
        n0 = 0; n1 = 0; gnt_early = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            sample();
            if (!c_busy[0] && !c_busy[1]) return;
            if (c_busy[0]) n0++;
            if (c_busy[1]) n1++;
            if (c_gnt[0] || c_gnt[1]) gnt_early = 1'b1;
        end
        n0 = -1; n1 = -1;
    endtask

    task automatic test_reset();
        int n0, n1;
        bit early;
        drive(1'b1, 1'b0, BASE + 32'h3C, 4'h0, 32'h0);
        #3;
        sample();
        for (int d = 0; d < 2; d++) begin
            checks++; if (c_gnt[d] !== 1'b0) begin failures++; $display("FAIL reset_gnt[%0d] got=%b exp=0", d, c_gnt[d]); end
            checks++; if (c_rvalid[d] !== 1'b0) begin failures++; $display("FAIL reset_rvalid[%0d] got=%b exp=0", d, c_rvalid[d]); end
            checks++; if (c_rdata[d] !== 32'h0 || c_err[d] !== 1'b0) begin failures++; $display("FAIL reset_resp[%0d] got=%h/%b exp=0/0", d, c_rdata[d], c_err[d]); end
            checks++; if (c_busy[d] !== 1'b1) begin failures++; $display("FAIL reset_busy[%0d] got=%b exp=1", d, c_busy[d]); end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        count_busy(n0, n1, early);
        checks++; if (n0 !== DEPTH || n1 !== DEPTH) begin failures++; $display("FAIL init_len got=%0d/%0d exp=%0d", n0, n1, DEPTH); end
        checks++; if (early) begin failures++; $display("FAIL init_gnt got=granted exp=no grant while busy"); end
        checks++; if (c_gnt[0] !== 1'b1 || c_gnt[1] !== 1'b1) begin failures++; $display("FAIL first_ready_gnt got=%b/%b exp=1", c_gnt[0], c_gnt[1]); end
        model_clear();
        @(posedge clk);
        #1;
        step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        for (int d = 0; d < 2; d++) begin
            checks++; if (c_rvalid[d] !== 1'b1 || c_rdata[d] !== 32'h0 || c_err[d] !== 1'b0) begin
                failures++; $display("FAIL read_cleared[%0d] got=%b/%h/%b exp=1/00000000/0", d, c_rvalid[d], c_rdata[d], c_err[d]);
            end
        end
    endtask

    task automatic test_byte_enables();
        logic        e_err;
        logic [31:0] e_rd;
        step(1'b1, 1'b1, BASE + 32'h8, 4'b1111, 32'h1122_3344);
        model_access(1'b1, BASE + 32'h8, 4'b1111, 32'h1122_3344, e_err, e_rd);
        checks++; if (c_gnt[0] !== 1'b1 || c_gnt[1] !== 1'b1) begin failures++; $display("FAIL be_gnt got=%b/%b exp=1", c_gnt[0], c_gnt[1]); end
        step(1'b1, 1'b1, BASE + 32'h8, 4'b0101, 32'hAABB_CCDD);
        model_access(1'b1, BASE + 32'h8, 4'b0101, 32'hAABB_CCDD, e_err, e_rd);
        for (int d = 0; d < 2; d++) begin
            checks++; if (c_rvalid[d] !== 1'b1 || c_rdata[d] !== 32'h0 || c_err[d] !== 1'b0) begin
                failures++; $display("FAIL be_wresp[%0d] got=%b/%h/%b exp=1/00000000/0", d, c_rvalid[d], c_rdata[d], c_err[d]);
            end
        end
        step(1'b1, 1'b0, BASE + 32'h8, 4'b0000, 32'h0);
        step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        for (int d = 0; d < 2; d++) begin
            checks++; if (c_rvalid[d] !== 1'b1 || c_rdata[d] !== 32'h11BB_33DD || c_err[d] !== 1'b0) begin
                failures++; $display("FAIL be_read[%0d] got=%b/%h/%b exp=1/11bb33dd/0", d, c_rvalid[d], c_rdata[d], c_err[d]);
            end
        end
        // Zero byte-enable write: responded to, memory unchanged.
        step(1'b1, 1'b1, BASE + 32'h8, 4'b0000, 32'hFFFF_FFFF);
        step(1'b1, 1'b0, BASE + 32'h8, 4'b0000, 32'h0);
        step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        for (int d = 0; d < 2; d++) begin
            checks++; if (c_rdata[d] !== 32'h11BB_33DD) begin failures++; $display("FAIL be_zero[%0d] got=%h exp=11bb33dd", d, c_rdata[d]); end
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] w0;
        w0 = model[0];
        step(1'b1, 1'b0, BASE + 32'h40, 4'hF, 32'h0);
        step(1'b1, 1'b1, 32'h0000_0000, 4'hF, 32'hDEAD_BEEF);
        for (int d = 0; d < 2; d++) begin
            checks++; if (c_rvalid[d] !== 1'b1 || c_err[d] !== 1'b1 || c_rdata[d] !== 32'h0) begin
                failures++; $display("FAIL oob_read[%0d] got=%b/%b/%h exp=1/1/00000000", d, c_rvalid[d], c_err[d], c_rdata[d]);
            end
        end
        step(1'b1, 1'b1, BASE - 32'h4, 4'hF, 32'hCAFE_F00D);
        for (int d = 0; d < 2; d++) begin
            checks++; if (c_err[d] !== 1'b1 || c_rdata[d] !== 32'h0) begin failures++; $display("FAIL oob_write[%0d] got=%b/%h exp=1/00000000", d, c_err[d], c_rdata[d]); end
        end
        step(1'b1, 1'b0, BASE, 4'h0, 32'h0);
        checks++; if (c_err[0] !== 1'b1 || c_err[1] !== 1'b1) begin failures++; $display("FAIL oob_below got=%b/%b exp=1", c_err[0], c_err[1]); end
        step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        for (int d = 0; d < 2; d++) begin
            checks++; if (c_err[d] !== 1'b0 || c_rdata[d] !== w0) begin failures++; $display("FAIL oob_readback[%0d] got=%b/%h exp=0/%h", d, c_err[d], c_rdata[d], w0); end
        end
    endtask

    task automatic test_swap_lanes();
        logic        e_err;
        logic [31:0] e_rd;
        step(1'b1, 1'b1, BASE + 32'h4, 4'hF, 32'h1122_3344);
        model_access(1'b1, BASE + 32'h4, 4'hF, 32'h1122_3344, e_err, e_rd);
        step(1'b1, 1'b0, BASE + 32'h4, 4'h0, 32'h0);
        checks++; if (dut_sw.u_array.mem_q[1] !== 32'h4433_2211) begin failures++; $display("FAIL swap_lane_sw got=%h exp=44332211", dut_sw.u_array.mem_q[1]); end
        checks++; if (dut_ns.u_array.mem_q[1] !== 32'h1122_3344) begin failures++; $display("FAIL swap_lane_ns got=%h exp=11223344", dut_ns.u_array.mem_q[1]); end
        step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        for (int d = 0; d < 2; d++) begin
            checks++; if (c_rdata[d] !== 32'h1122_3344) begin failures++; $display("FAIL swap_read[%0d] got=%h exp=11223344", d, c_rdata[d]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addr, wd, prd, e_rd;
        logic        pv, perr, e_err, we;
        int          grants, valids;
        addr = BASE + 32'h4 * $urandom_range(0, DEPTH - 1);
        pv = 1'b0; prd = 32'h0; perr = 1'b0; grants = 0; valids = 0;
        for (int k = 0; k < 9; k++) begin
            we = (k % 2 == 0);
            wd = $urandom;
            step(k < 8, we, addr, 4'hF, wd);
            for (int d = 0; d < 2; d++) begin
                checks++; if (c_rvalid[d] !== pv || c_rdata[d] !== prd || c_err[d] !== perr) begin
                    failures++; $display("FAIL b2b_resp[%0d] k=%0d got=%b/%h/%b exp=%b/%h/%b", d, k, c_rvalid[d], c_rdata[d], c_err[d], pv, prd, perr);
                end
            end
            if (c_gnt[0]) grants++;
            if (c_rvalid[0]) valids++;
            pv = (k < 8); prd = 32'h0; perr = 1'b0;
            if (k < 8) begin
                model_access(we, addr, 4'hF, wd, e_err, e_rd);
                prd = e_rd; perr = e_err;
            end
        end
        checks++; if (grants !== 8 || valids !== 8) begin failures++; $display("FAIL b2b_count got=%0d/%0d exp=8/8", grants, valids); end
    endtask

    task automatic test_random(input int n);
        logic [31:0] addr, wd, prd, e_rd;
        logic [3:0]  be;
        logic        req, we, pv, perr, e_err;
        pv = 1'b0; prd = 32'h0; perr = 1'b0;
        for (int k = 0; k <= n; k++) begin
            req  = (k < n) && ($urandom_range(0, 3) != 0);
            we   = 1'($urandom_range(0, 1));
            be   = 4'($urandom);
            wd   = $urandom;
            addr = ($urandom_range(0, 7) == 0) ? $urandom : BASE + 32'($urandom_range(0, DEPTH * 4 - 1));
            step(req, we, addr, be, wd);
            for (int d = 0; d < 2; d++) begin
                checks++; if (c_gnt[d] !== req) begin failures++; $display("FAIL rand_gnt[%0d] k=%0d got=%b exp=%b", d, k, c_gnt[d], req); end
                checks++; if (c_rvalid[d] !== pv || c_rdata[d] !== prd || c_err[d] !== perr) begin
                    failures++; $display("FAIL rand_resp[%0d] k=%0d got=%b/%h/%b exp=%b/%h/%b", d, k, c_rvalid[d], c_rdata[d], c_err[d], pv, prd, perr);
                end
            end
            pv = req; prd = 32'h0; perr = 1'b0;
            if (req) begin
                model_access(we, addr, be, wd, e_err, e_rd);
                prd = e_rd; perr = e_err;
            end
        end
    endtask

    task automatic test_mid_init_reset();
        int n0, n1;
        bit early;
        drive(1'b1, 1'b0, BASE + 32'h10, 4'h0, 32'h0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        sample();
        for (int d = 0; d < 2; d++) begin
            checks++; if (c_gnt[d] !== 1'b0 || c_busy[d] !== 1'b1) begin failures++; $display("FAIL rst_async[%0d] got=gnt %b busy %b exp=0/1", d, c_gnt[d], c_busy[d]); end
        end
        @(posedge clk);
        #1;
        sample();
        for (int d = 0; d < 2; d++) begin
            checks++; if (c_rvalid[d] !== 1'b0 || c_rdata[d] !== 32'h0 || c_err[d] !== 1'b0) begin
                failures++; $display("FAIL rst_discard[%0d] got=%b/%h/%b exp=0/00000000/0", d, c_rvalid[d], c_rdata[d], c_err[d]);
            end
        end
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        sample();
        checks++; if (c_busy[0] !== 1'b1 || c_gnt[0] !== 1'b0) begin failures++; $display("FAIL mid_init_rst got=busy %b gnt %b exp=1/0", c_busy[0], c_gnt[0]); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        count_busy(n0, n1, early);
        checks++; if (n0 !== DEPTH || n1 !== DEPTH) begin failures++; $display("FAIL restart_len got=%0d/%0d exp=%0d", n0, n1, DEPTH); end
        checks++; if (early) begin failures++; $display("FAIL restart_gnt got=granted exp=no grant while busy"); end
        checks++; if (c_gnt[0] !== 1'b1 || c_gnt[1] !== 1'b1) begin failures++; $display("FAIL restart_first_gnt got=%b/%b exp=1", c_gnt[0], c_gnt[1]); end
        model_clear();
        @(posedge clk);
        #1;
        step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        for (int d = 0; d < 2; d++) begin
            checks++; if (c_rvalid[d] !== 1'b1 || c_rdata[d] !== 32'h0 || c_err[d] !== 1'b0) begin
                failures++; $display("FAIL restart_read[%0d] got=%b/%h/%b exp=1/00000000/0", d, c_rvalid[d], c_rdata[d], c_err[d]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_byte_enables();
        test_out_of_range();
        test_swap_lanes();
        test_back_to_back();
        test_random(60);
        test_mid_init_reset();
        test_random(30);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=completion");
        $fatal(1);
    end

endmodule
